// File: rtl/alu_dot8_pe_pkg.sv
// Shared types for the ALU block: header layouts and the dot8 product bundle.
package VX_gpu_pkg;

  localparam int UUID_WIDTH    = 44;
  localparam int NW_WIDTH      = 2;
  localparam int PC_BITS       = 30;
  localparam int NR_BITS       = 6;
  localparam int PID_WIDTH     = 1;
  localparam int NUM_ALU_LANES = 4;
  localparam int DOT8_LATENCY  = 2;

  // Four int8 x int8 products of one lane, carried from S1 to S2.
  typedef logic signed [3:0][15:0] dot8_prod_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [PC_BITS-1:0]    PC;
    logic [NR_BITS-1:0]    rd;
    logic                  wb;
    logic [PID_WIDTH-1:0]  pid;
    logic                  sop;
    logic                  eop;
  } alu_exe_t;

  typedef alu_exe_t alu_res_t;

endpackage

// File: rtl/alu_dot8_pe_lane.sv
// One lane of the dot8 PE: S1 holds the four byte products, S2 holds the
// sign-extended adder-tree sum. Enables come from the shared pipeline control.
module alu_dot8_lane
  import VX_gpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            en1,
  input  logic            en2,
  input  logic            lane_en,
  input  logic [31:0]     rs1,
  input  logic [31:0]     rs2,
  output logic [XLEN-1:0] sum
);

  dot8_prod_t      prod_d, prod_q;
  logic [XLEN-1:0] sum_d, sum_q;
  logic [17:0]     tree;

  always_comb begin
    prod_d = prod_q;
    if (en1) begin
      for (int k = 0; k < 4; k++) begin
        // Inactive lanes load zero products so the sum is zero as well.
        if (lane_en) begin
          prod_d[k] = $signed({{8{rs1[8*k+7]}}, rs1[8*k +: 8]})
                    * $signed({{8{rs2[8*k+7]}}, rs2[8*k +: 8]});
        end else begin
          prod_d[k] = '0;
        end
      end
    end
  end

  always_comb begin
    tree = {{2{prod_q[0][15]}}, prod_q[0]}
         + {{2{prod_q[1][15]}}, prod_q[1]}
         + {{2{prod_q[2][15]}}, prod_q[2]}
         + {{2{prod_q[3][15]}}, prod_q[3]};
    sum_d = sum_q;
    if (en2) begin
      sum_d = {{(XLEN-18){tree[17]}}, tree};
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/alu_dot8_pe.sv
// Two-stage packed int8 dot-product PE with per-stage valid/ready so bubbles
// collapse and backpressure holds both stages without loss or reordering.
module alu_dot8_pe
  import VX_gpu_pkg::*;
#(
  parameter int NUM_LANES = NUM_ALU_LANES,
  parameter int XLEN      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      execute_valid,
  output logic                      execute_ready,
  input  logic [UUID_WIDTH-1:0]     execute_uuid,
  input  logic [NW_WIDTH-1:0]       execute_wid,
  input  logic [PC_BITS-1:0]        execute_PC,
  input  logic [NR_BITS-1:0]        execute_rd,
  input  logic                      execute_wb,
  input  logic [PID_WIDTH-1:0]      execute_pid,
  input  logic                      execute_sop,
  input  logic                      execute_eop,
  input  logic [NUM_LANES-1:0]      execute_tmask,
  input  logic [NUM_LANES*XLEN-1:0] execute_rs1_data,
  input  logic [NUM_LANES*XLEN-1:0] execute_rs2_data,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [UUID_WIDTH-1:0]     result_uuid,
  output logic [NW_WIDTH-1:0]       result_wid,
  output logic [PC_BITS-1:0]        result_PC,
  output logic [NR_BITS-1:0]        result_rd,
  output logic                      result_wb,
  output logic [PID_WIDTH-1:0]      result_pid,
  output logic                      result_sop,
  output logic                      result_eop,
  output logic [NUM_LANES-1:0]      result_tmask,
  output logic [NUM_LANES*XLEN-1:0] result_data
);

  logic                 v1_d, v1_q, v2_d, v2_q;
  logic                 en1, en2;
  alu_exe_t             hdr1_d, hdr1_q;
  alu_res_t             hdr2_d, hdr2_q;
  logic [NUM_LANES-1:0] tmask1_d, tmask1_q, tmask2_d, tmask2_q;

  always_comb begin
    en2 = ~v2_q | result_ready;
    en1 = ~v1_q | en2;

    v1_d     = v1_q;
    hdr1_d   = hdr1_q;
    tmask1_d = tmask1_q;
    v2_d     = v2_q;
    hdr2_d   = hdr2_q;
    tmask2_d = tmask2_q;

    if (en1) begin
      v1_d        = execute_valid;
      hdr1_d.uuid = execute_uuid;
      hdr1_d.wid  = execute_wid;
      hdr1_d.PC   = execute_PC;
      hdr1_d.rd   = execute_rd;
      hdr1_d.wb   = execute_wb;
      hdr1_d.pid  = execute_pid;
      hdr1_d.sop  = execute_sop;
      hdr1_d.eop  = execute_eop;
      tmask1_d    = execute_tmask;
    end
    if (en2) begin
      v2_d     = v1_q;
      hdr2_d   = hdr1_q;
      tmask2_d = tmask1_q;
    end
  end

  // Only the valid bits are reset; payload registers are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
    hdr1_q   <= hdr1_d;
    tmask1_q <= tmask1_d;
    hdr2_q   <= hdr2_d;
    tmask2_q <= tmask2_d;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    alu_dot8_lane #(
      .XLEN(XLEN)
    ) u_lane (
      .clk    (clk),
      .en1    (en1),
      .en2    (en2),
      .lane_en(execute_tmask[i]),
      .rs1    (execute_rs1_data[i*XLEN +: 32]),
      .rs2    (execute_rs2_data[i*XLEN +: 32]),
      .sum    (result_data[i*XLEN +: XLEN])
    );
  end

  assign execute_ready = en1;
  assign result_valid  = v2_q;
  assign result_uuid   = hdr2_q.uuid;
  assign result_wid    = hdr2_q.wid;
  assign result_PC     = hdr2_q.PC;
  assign result_rd     = hdr2_q.rd;
  assign result_wb     = hdr2_q.wb;
  assign result_pid    = hdr2_q.pid;
  assign result_sop    = hdr2_q.sop;
  assign result_eop    = hdr2_q.eop;
  assign result_tmask  = tmask2_q;

endmodule

// File: tb/tb_alu_dot8_pe.sv
// Self-checking bench for alu_dot8_pe: directed vector table, pipeline corner
// sequences and a randomized stream checked against a queue-based reference.
module tb_alu_dot8_pe;
   import VX_gpu_pkg::*;

   localparam int NL = 4;
   localparam int XL = 32;

   logic               clk;
   logic               reset;
   logic               execute_valid;
   logic               execute_ready;
   logic [UUID_WIDTH-1:0] execute_uuid;
   logic [NW_WIDTH-1:0]   execute_wid;
   logic [PC_BITS-1:0]    execute_PC;
   logic [NR_BITS-1:0]    execute_rd;
   logic                  execute_wb;
   logic [PID_WIDTH-1:0]  execute_pid;
   logic                  execute_sop;
   logic                  execute_eop;
   logic [NL-1:0]         execute_tmask;
   logic [NL*XL-1:0]      execute_rs1_data;
   logic [NL*XL-1:0]      execute_rs2_data;
   logic                  result_valid;
   logic                  result_ready;
   logic [UUID_WIDTH-1:0] result_uuid;
   logic [NW_WIDTH-1:0]   result_wid;
   logic [PC_BITS-1:0]    result_PC;
   logic [NR_BITS-1:0]    result_rd;
   logic                  result_wb;
   logic [PID_WIDTH-1:0]  result_pid;
   logic                  result_sop;
   logic                  result_eop;
   logic [NL-1:0]         result_tmask;
   logic [NL*XL-1:0]      result_data;

   alu_dot8_pe #(.NUM_LANES(NL), .XLEN(XL)) dut (
      .clk(clk), .reset(reset),
      .execute_valid(execute_valid), .execute_ready(execute_ready),
      .execute_uuid(execute_uuid), .execute_wid(execute_wid), .execute_PC(execute_PC),
      .execute_rd(execute_rd), .execute_wb(execute_wb), .execute_pid(execute_pid),
      .execute_sop(execute_sop), .execute_eop(execute_eop), .execute_tmask(execute_tmask),
      .execute_rs1_data(execute_rs1_data), .execute_rs2_data(execute_rs2_data),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_uuid(result_uuid), .result_wid(result_wid), .result_PC(result_PC),
      .result_rd(result_rd), .result_wb(result_wb), .result_pid(result_pid),
      .result_sop(result_sop), .result_eop(result_eop), .result_tmask(result_tmask),
      .result_data(result_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      alu_exe_t          hdr;
      logic [NL-1:0]     tmask;
      logic [NL*XL-1:0]  data;
   } expItem_t;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [3:0]  tmask;
      logic [31:0] expLane;
   } vec_t;

   expItem_t expQ[$];
   int errors = 0;
   int checks = 0;
   int popped = 0;
   int randDone = 0;

   // Reference: signed byte products summed per lane, zero for masked lanes.
   function automatic logic [NL*XL-1:0] refDot(logic [NL*XL-1:0] a, logic [NL*XL-1:0] b,
                                               logic [NL-1:0] m);
      logic [NL*XL-1:0] r;
      r = '0;
      for (int l = 0; l < NL; l++) begin
         int s;
         s = 0;
         for (int k = 0; k < 4; k++) begin
            byte x;
            byte y;
            x = a[l*XL + k*8 +: 8];
            y = b[l*XL + k*8 +: 8];
            s += int'(x) * int'(y);
         end
         if (m[l]) r[l*XL +: XL] = s;
      end
      return r;
   endfunction

   function automatic logic [NL*XL-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: record accepts, compare every valid output cycle against the queue head.
   always @(negedge clk) begin
      if (reset) begin
         expQ.delete();
      end else begin
         if (result_valid) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL spurious_result: got uuid %h expected no result", result_uuid);
            end else begin
               alu_exe_t act;
               act.uuid = result_uuid; act.wid = result_wid; act.PC = result_PC;
               act.rd = result_rd; act.wb = result_wb; act.pid = result_pid;
               act.sop = result_sop; act.eop = result_eop;
               checkVal("sb_data", result_data, expQ[0].data);
               checkVal("sb_header", 128'(act), 128'(expQ[0].hdr));
               checkVal("sb_tmask", 128'(result_tmask), 128'(expQ[0].tmask));
               if (result_ready) begin
                  void'(expQ.pop_front());
                  popped++;
               end
            end
         end
         if (execute_valid && execute_ready) begin
            expItem_t it;
            it.hdr.uuid = execute_uuid; it.hdr.wid = execute_wid; it.hdr.PC = execute_PC;
            it.hdr.rd = execute_rd; it.hdr.wb = execute_wb; it.hdr.pid = execute_pid;
            it.hdr.sop = execute_sop; it.hdr.eop = execute_eop;
            it.tmask = execute_tmask;
            it.data = refDot(execute_rs1_data, execute_rs2_data, execute_tmask);
            expQ.push_back(it);
         end
      end
   end

   // Presents one request and holds it until accepted; returns just after the accepting edge.
   task automatic applyStimulus(input logic [UUID_WIDTH-1:0] uuid, input logic [NL-1:0] tmask,
                                input logic [NL*XL-1:0] rs1, input logic [NL*XL-1:0] rs2);
      bit accepted;
      execute_uuid = uuid;
      execute_wid = NW_WIDTH'($urandom);
      execute_PC = PC_BITS'($urandom);
      execute_rd = NR_BITS'($urandom);
      execute_wb = 1'($urandom);
      execute_pid = PID_WIDTH'($urandom);
      execute_sop = 1'($urandom);
      execute_eop = 1'($urandom);
      execute_tmask = tmask;
      execute_rs1_data = rs1;
      execute_rs2_data = rs2;
      execute_valid = 1'b1;
      accepted = 0;
      for (int c = 0; c < 100 && !accepted; c++) begin
         @(negedge clk);
         if (execute_ready) accepted = 1;
         @(posedge clk); #1;
      end
      execute_valid = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got no accept expected accept of uuid %h", uuid);
      end
   endtask

   // Waits for the next valid result and compares it with a table entry.
   task automatic checkOutput(input string name, input vec_t v, input logic [UUID_WIDTH-1:0] uuid);
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (result_valid) seen = 1;
         else begin @(posedge clk); #1; end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got no result_valid expected one", name);
      end else begin
         for (int l = 0; l < NL; l++)
            checkVal($sformatf("%s_lane%0d", name, l), 128'(result_data[l*XL +: XL]),
                     128'(v.tmask[l] ? v.expLane : 32'h0));
         checkVal({name, "_tmask"}, 128'(result_tmask), 128'(v.tmask));
         checkVal({name, "_uuid"}, 128'(result_uuid), 128'(uuid));
         @(posedge clk); #1;
      end
   endtask

   task automatic waitDrain(input string name);
      for (int c = 0; c < 200 && expQ.size() != 0; c++) begin
         @(posedge clk); #1;
      end
      checkVal({name, "_drained"}, 128'(expQ.size()), 128'(0));
   endtask

   vec_t vecs[5];

   initial begin
      int p0;
      vecs[0] = '{32'h01020304, 32'h05060708, 4'hF, 32'h00000046};
      vecs[1] = '{32'h80808080, 32'h80808080, 4'hF, 32'h00010000};
      vecs[2] = '{32'hFFFFFFFF, 32'h01010101, 4'hF, 32'hFFFFFFFC};
      vecs[3] = '{32'h7F7F7F7F, 32'h80808080, 4'hF, 32'hFFFF0200};
      vecs[4] = '{32'h01020304, 32'h05060708, 4'b0101, 32'h00000046};

      reset = 1'b1;
      execute_valid = 1'b0;
      result_ready = 1'b1;
      execute_uuid = '0; execute_wid = '0; execute_PC = '0; execute_rd = '0;
      execute_wb = 1'b0; execute_pid = '0; execute_sop = 1'b0; execute_eop = 1'b0;
      execute_tmask = '0; execute_rs1_data = '0; execute_rs2_data = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checkVal("reset_result_valid", 128'(result_valid), 128'(0));
      @(posedge clk); #1;
      reset = 1'b0;

      $display("[TB] latency check");
      execute_uuid = 44'd100; execute_tmask = 4'hF;
      execute_rs1_data = {4{32'h01020304}}; execute_rs2_data = {4{32'h05060708}};
      execute_valid = 1'b1;
      @(negedge clk);
      checkVal("lat_execute_ready", 128'(execute_ready), 128'(1));
      @(posedge clk); #1;
      execute_valid = 1'b0;
      for (int c = 1; c <= DOT8_LATENCY; c++) begin
         @(negedge clk);
         checkVal($sformatf("lat_valid_c%0d", c), 128'(result_valid), 128'(c == DOT8_LATENCY));
         if (c == DOT8_LATENCY)
            checkVal("lat_data", result_data, 128'({4{32'h00000046}}));
         @(posedge clk); #1;
      end

      $display("[TB] vector table");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(44'(200 + i), vecs[i].tmask, {4{vecs[i].rs1}}, {4{vecs[i].rs2}});
         checkOutput($sformatf("vec%0d", i), vecs[i], 44'(200 + i));
      end

      $display("[TB] backpressure stream");
      p0 = popped;
      result_ready = 1'b1;
      fork
         begin
            for (int i = 1; i <= 6; i++) applyStimulus(44'(i), 4'hF, rand128(), rand128());
         end
         begin
            int w;
            w = 0;
            while (!result_valid && w < 50) begin @(posedge clk); #1; w++; end
            if (w >= 50) begin
               checks++; errors++;
               $display("[TB] FAIL bp_first_valid: got none expected result_valid");
            end
            result_ready = 1'b0;
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               checkVal("bp_execute_ready", 128'(execute_ready), 128'(0));
               checkVal("bp_result_valid", 128'(result_valid), 128'(1));
               @(posedge clk); #1;
            end
            result_ready = 1'b1;
         end
      join
      waitDrain("bp");
      checkVal("bp_count", 128'(popped - p0), 128'(6));

      $display("[TB] bubble collapse");
      result_ready = 1'b0;
      applyStimulus(44'd300, 4'hF, rand128(), rand128());
      @(negedge clk);
      checkVal("bub_s1_valid", 128'(result_valid), 128'(0));
      checkVal("bub_s1_ready", 128'(execute_ready), 128'(1));
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("bub_s2_valid", 128'(result_valid), 128'(1));
      checkVal("bub_s2_ready", 128'(execute_ready), 128'(1));
      @(posedge clk); #1;
      applyStimulus(44'd301, 4'hA, rand128(), rand128());
      @(negedge clk);
      checkVal("bub_full_ready", 128'(execute_ready), 128'(0));
      @(posedge clk); #1;
      result_ready = 1'b1;
      waitDrain("bub");

      $display("[TB] reset in flight");
      result_ready = 1'b0;
      applyStimulus(44'd400, 4'hF, rand128(), rand128());
      applyStimulus(44'd401, 4'hF, rand128(), rand128());
      execute_rs1_data = rand128();
      execute_valid = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      execute_valid = 1'b0;
      @(negedge clk);
      checkVal("rst_result_valid", 128'(result_valid), 128'(0));
      result_ready = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      checkVal("rst_quiet", 128'(result_valid), 128'(0));
      checkVal("rst_queue", 128'(expQ.size()), 128'(0));

      $display("[TB] random stream");
      p0 = popped;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
               applyStimulus(44'(1000 + i), 4'($urandom), rand128(), rand128());
            end
            randDone = 1;
         end
         begin
            while (!randDone) begin
               result_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
            result_ready = 1'b1;
         end
      join
      waitDrain("rand");
      checkVal("rand_count", 128'(popped - p0), 128'(40));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
